// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the 8-bit ALU and its write-back stage:
//               status-flag bit positions, opcode encodings for sel 0..14 and
//               the packed {sel, flags, data} write-back entry.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Bit positions inside a 4-bit {N,V,C,Z} flag vector
    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;
    localparam int FLG_N = 3;

    // ALU opcode encodings carried on sel
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_SAR   = 4'd8;
    localparam logic [3:0] OP_ROL   = 4'd9;
    localparam logic [3:0] OP_ROR   = 4'd10;
    localparam logic [3:0] OP_INC   = 4'd11;
    localparam logic [3:0] OP_DEC   = 4'd12;
    localparam logic [3:0] OP_PASSX = 4'd13;
    localparam logic [3:0] OP_PASSY = 4'd14;

    // Native ALU data width
    localparam int ALU_W = 8;

    // One write-back entry; field order matches the FIFO word layout
    typedef struct packed {
        logic [3:0]       sel;
        logic [3:0]       flags;
        logic [ALU_W-1:0] data;
    } alu_wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_fifo
// Description : Generic synchronous FIFO, DEPTH entries of W bits. The head
//               word is presented combinationally from storage. Pushes into a
//               full FIFO and pops from an empty FIFO are ignored.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               i_push       - write i_wdata at the tail
//               i_pop        - drop the head entry
//               i_wdata      - tail write data
//               o_rdata      - current head word (undefined when empty)
//               o_count      - number of stored entries, 0..DEPTH
//               o_empty      - o_count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_wdata,
    output logic [W-1:0]               o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);

    localparam int unsigned             c_PTR_W = $clog2(DEPTH);
    localparam int unsigned             c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]      c_FULL  = c_CNT_W'(DEPTH);

    logic [W-1:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_full;
    logic                 w_wr;
    logic                 w_rd;

    assign w_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign w_wr    = i_push & ~w_full;
    assign w_rd    = i_pop & ~o_empty;

    // DEPTH is a power of two, so pointers wrap naturally on overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/alu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_stage
// Description : Write-back stage behind the 8-bit ALU. Accepts results with
//               their flags and opcode over valid/ready, buffers them in a
//               small FIFO toward the consumer, and keeps the architectural
//               {N,V,C,Z} status register, a sticky overflow bit and an
//               accepted-operation counter.
// Config      : ALU_WB_BYPASS_EN - when defined, an empty stage forwards an
//               incoming result straight to out_* in the same cycle if the
//               consumer is ready (entry is not written into the FIFO).
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - producer handshake
//               in_data, in_sel     - ALU result and opcode
//               in_zero/carry/overflow/negative - ALU flags
//               out_valid/out_ready - consumer handshake
//               out_data/flags/sel  - head entry, flags as {N,V,C,Z}
//               status              - architectural flags {N,V,C,Z}
//               sticky_ovf          - any accepted overflow since clear
//               clr_sticky          - clears sticky_ovf (a same-edge set wins)
//               op_count            - accepted results, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 2,
    parameter logic [15:0] FLAG_MASK = 16'h7FFF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       in_sel,
    input  logic             in_zero,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic             in_negative,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_flags,
    output logic [3:0]       out_sel,
    output logic [3:0]       status,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned            c_CNT_BITS  = $clog2(DEPTH) + 1;
    localparam int unsigned            c_ENTRY_W   = WIDTH + 8;
    localparam logic [c_CNT_BITS-1:0]  c_DEPTH_CNT = c_CNT_BITS'(DEPTH);

    logic [3:0]              w_in_flags;
    logic [c_ENTRY_W-1:0]    w_push_entry;
    logic [c_ENTRY_W-1:0]    w_fifo_head;
    logic [c_ENTRY_W-1:0]    w_head;
    logic [c_ENTRY_W-1:0]    r_last;
    logic [c_CNT_BITS-1:0]   w_count;
    logic                    w_empty;
    logic                    w_accept;
    logic                    w_bypass;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_out_valid;
    logic [3:0]              r_status;
    logic                    r_sticky;
    logic [CNT_W-1:0]        r_op_count;

    // Flags are passed through exactly as the ALU produced them
    always_comb begin
        w_in_flags        = '0;
        w_in_flags[FLG_N] = in_negative;
        w_in_flags[FLG_V] = in_overflow;
        w_in_flags[FLG_C] = in_carry;
        w_in_flags[FLG_Z] = in_zero;
    end

    assign w_push_entry = {in_sel, w_in_flags, in_data};

    // in_ready depends only on the registered occupancy, so a full FIFO
    // refuses a push even in a cycle where the consumer pops
    assign in_ready = (w_count < c_DEPTH_CNT);
    assign w_accept = in_valid & in_ready;

`ifdef ALU_WB_BYPASS_EN
    assign w_bypass = w_empty & in_valid & out_ready;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed result is delivered directly and never occupies storage
    assign w_push      = w_accept & ~w_bypass;
    assign w_pop       = ~w_empty & out_ready;
    assign w_out_valid = ~w_empty | w_bypass;

    alu_wb_fifo #(
        .DEPTH (DEPTH),
        .W     (c_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_push_entry),
        .o_rdata (w_fifo_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // While empty, the outputs repeat the last delivered entry (zero after
    // reset) rather than whatever stale word the read pointer points at
    always_comb begin
        w_head = r_last;
        if (w_bypass) begin
            w_head = w_push_entry;
        end else if (!w_empty) begin
            w_head = w_fifo_head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= '0;
            r_status   <= '0;
            r_sticky   <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_out_valid && out_ready) begin
                r_last <= w_head;
            end
            // Status tracks acceptance order, not delivery order
            if (w_accept) begin
                r_op_count <= r_op_count + CNT_W'(1);
                if (FLAG_MASK[in_sel]) begin
                    r_status <= w_in_flags;
                end
            end
            if (w_accept && in_overflow) begin
                r_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign out_valid  = w_out_valid;
    assign out_sel    = w_head[c_ENTRY_W-1 -: 4];
    assign out_flags  = w_head[WIDTH+3:WIDTH];
    assign out_data   = w_head[WIDTH-1:0];
    assign status     = r_status;
    assign sticky_ovf = r_sticky;
    assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_wb_stage
// Description : Self-checking bench for alu_wb_stage. Two instances share all
//               inputs: one with the default FLAG_MASK and one with
//               FLAG_MASK=16'h0001. A queue-based reference model predicts
//               every output each cycle; a directed table adds hand-derived
//               expectations, followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_wb_stage;
    import alu_pkg::*;

    localparam int          DEPTH  = 2;
    localparam int          CNT_W  = 16;
    localparam logic [15:0] MASK_A = 16'h7FFF;
    localparam logic [15:0] MASK_B = 16'h0001;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [3:0]       in_sel;
    logic             in_zero, in_carry, in_overflow, in_negative;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [3:0]       out_flags;
    logic [3:0]       out_sel;
    logic [3:0]       status;
    logic             sticky_ovf;
    logic             clr_sticky;
    logic [CNT_W-1:0] op_count;

    logic             m_in_ready, m_out_valid, m_sticky_ovf;
    logic [7:0]       m_out_data;
    logic [3:0]       m_out_flags, m_out_sel, m_status;
    logic [CNT_W-1:0] m_op_count;

    always #5 clk = ~clk;

    alu_wb_stage #(.WIDTH(8), .DEPTH(DEPTH), .FLAG_MASK(MASK_A), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_zero(in_zero), .in_carry(in_carry),
        .in_overflow(in_overflow), .in_negative(in_negative),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .out_sel(out_sel), .status(status),
        .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky), .op_count(op_count)
    );

    alu_wb_stage #(.WIDTH(8), .DEPTH(DEPTH), .FLAG_MASK(MASK_B), .CNT_W(CNT_W)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_zero(in_zero), .in_carry(in_carry),
        .in_overflow(in_overflow), .in_negative(in_negative),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data),
        .out_flags(m_out_flags), .out_sel(m_out_sel), .status(m_status),
        .sticky_ovf(m_sticky_ovf), .clr_sticky(clr_sticky), .op_count(m_op_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    alu_wb_entry_t    q[$];
    alu_wb_entry_t    md_last;
    logic [3:0]       md_st, md_stm;
    logic             md_sticky;
    logic [CNT_W-1:0] md_cnt;

    typedef struct {
        logic       rst, iv;
        logic [7:0] d;
        logic [3:0] s, f;
        logic       ordy, clr;
        logic       e_ir, e_ov;
        logic [7:0] e_od;
        logic [3:0] e_st, e_stm;
        logic       e_sticky;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vec [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [7:0] d,
                         input logic [3:0] s, input logic [3:0] f,
                         input logic ordy, input logic clr);
        rst         = r;
        in_valid    = iv;
        in_data     = d;
        in_sel      = s;
        in_negative = f[3];
        in_overflow = f[2];
        in_carry    = f[1];
        in_zero     = f[0];
        out_ready   = ordy;
        clr_sticky  = clr;
    endtask

    function automatic alu_wb_entry_t cur_in();
        alu_wb_entry_t e;
        e.sel   = in_sel;
        e.flags = {in_negative, in_overflow, in_carry, in_zero};
        e.data  = in_data;
        return e;
    endfunction

    function automatic bit model_bypass();
        bit b = 1'b0;
`ifdef ALU_WB_BYPASS_EN
        b = (q.size() == 0) && in_valid && out_ready;
`endif
        return b;
    endfunction

    function automatic alu_wb_entry_t model_head();
        if (q.size() > 0) return q[0];
        if (model_bypass()) return cur_in();
        return md_last;
    endfunction

    task automatic model_check();
        alu_wb_entry_t h;
        h = model_head();
        chk("in_ready",   {31'd0, in_ready},   {31'd0, q.size() < DEPTH});
        chk("out_valid",  {31'd0, out_valid},  {31'd0, (q.size() > 0) || model_bypass()});
        chk("out_data",   {24'd0, out_data},   {24'd0, h.data});
        chk("out_flags",  {28'd0, out_flags},  {28'd0, h.flags});
        chk("out_sel",    {28'd0, out_sel},    {28'd0, h.sel});
        chk("status",     {28'd0, status},     {28'd0, md_st});
        chk("status_m1",  {28'd0, m_status},   {28'd0, md_stm});
        chk("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, md_sticky});
        chk("op_count",   {16'd0, op_count},   {16'd0, md_cnt});
    endtask

    // Applies the effect of the upcoming clock edge to the model
    task automatic model_update();
        bit            ir, byp, ov, acc, del;
        alu_wb_entry_t h, ci;
        if (rst) begin
            q.delete();
            md_last   = '0;
            md_st     = '0;
            md_stm    = '0;
            md_sticky = 1'b0;
            md_cnt    = '0;
            return;
        end
        ir  = q.size() < DEPTH;
        byp = model_bypass();
        ov  = (q.size() > 0) || byp;
        h   = model_head();
        ci  = cur_in();
        acc = in_valid && ir;
        del = ov && out_ready;
        if (del) begin
            md_last = h;
            if (q.size() > 0) q.delete(0);
        end
        if (acc) begin
            if (!byp) q.push_back(ci);
            if (MASK_A[in_sel]) md_st  = ci.flags;
            if (MASK_B[in_sel]) md_stm = ci.flags;
            md_cnt = md_cnt + 16'd1;
        end
        if (acc && in_overflow) md_sticky = 1'b1;
        else if (clr_sticky)    md_sticky = 1'b0;
    endtask

    task automatic cycle_end(input bit do_check);
        if (do_check) model_check();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //           rst iv  d      s  f        ordy clr  ir ov od     st       stm      stk cnt
        vec[0]  = '{0, 1, 8'd40,  0, 4'b0000, 1, 0,  1, 0, 8'd0,  4'b0000, 4'b0000, 0, 16'd0};
        vec[1]  = '{0, 1, 8'd0,   0, 4'b0111, 1, 0,  1, 1, 8'd40, 4'b0000, 4'b0000, 0, 16'd1};
        vec[2]  = '{0, 1, 8'd5,   1, 4'b0100, 0, 1,  1, 1, 8'd0,  4'b0111, 4'b0111, 1, 16'd2};
        vec[3]  = '{0, 0, 8'd0,   0, 4'b0000, 0, 1,  0, 1, 8'd0,  4'b0100, 4'b0111, 1, 16'd3};
        vec[4]  = '{0, 0, 8'd0,   0, 4'b0000, 1, 0,  0, 1, 8'd0,  4'b0100, 4'b0111, 0, 16'd3};
        vec[5]  = '{0, 0, 8'd0,   0, 4'b0000, 1, 0,  1, 1, 8'd5,  4'b0100, 4'b0111, 0, 16'd3};
        vec[6]  = '{0, 1, 8'd10,  2, 4'b0000, 0, 0,  1, 0, 8'd5,  4'b0100, 4'b0111, 0, 16'd3};
        vec[7]  = '{0, 1, 8'd20,  2, 4'b0000, 0, 0,  1, 1, 8'd10, 4'b0000, 4'b0111, 0, 16'd4};
        vec[8]  = '{0, 1, 8'd30,  2, 4'b0000, 0, 0,  0, 1, 8'd10, 4'b0000, 4'b0111, 0, 16'd5};
        vec[9]  = '{0, 1, 8'd30,  2, 4'b0000, 1, 0,  0, 1, 8'd10, 4'b0000, 4'b0111, 0, 16'd5};
        vec[10] = '{0, 1, 8'd30,  2, 4'b0000, 1, 0,  1, 1, 8'd20, 4'b0000, 4'b0111, 0, 16'd5};
        vec[11] = '{0, 1, 8'h11,  0, 4'b0000, 1, 0,  1, 1, 8'd30, 4'b0000, 4'b0111, 0, 16'd6};
        vec[12] = '{0, 1, 8'd0,   5, 4'b0001, 1, 0,  1, 1, 8'h11, 4'b0000, 4'b0000, 0, 16'd7};
        vec[13] = '{0, 1, 8'd0,   0, 4'b0001, 0, 0,  1, 1, 8'd0,  4'b0001, 4'b0000, 0, 16'd8};
        vec[14] = '{1, 1, 8'h77,  0, 4'b0100, 0, 0,  0, 1, 8'd0,  4'b0001, 4'b0001, 0, 16'd9};
        vec[15] = '{0, 0, 8'd0,   0, 4'b0000, 0, 0,  1, 0, 8'd0,  4'b0000, 4'b0000, 0, 16'd0};

        drive(1, 0, 8'd0, 4'd0, 4'd0, 0, 0);
        @(negedge clk);
        cycle_end(0);
        cycle_end(0);

        // Directed table: expectations are the outputs visible while the row is applied
        for (int i = 0; i < 16; i++) begin
            drive(vec[i].rst, vec[i].iv, vec[i].d, vec[i].s, vec[i].f, vec[i].ordy, vec[i].clr);
            #1;
`ifndef ALU_WB_BYPASS_EN
            chk($sformatf("tab%0d in_ready", i),  {31'd0, in_ready},   {31'd0, vec[i].e_ir});
            chk($sformatf("tab%0d out_valid", i), {31'd0, out_valid},  {31'd0, vec[i].e_ov});
            chk($sformatf("tab%0d out_data", i),  {24'd0, out_data},   {24'd0, vec[i].e_od});
            chk($sformatf("tab%0d status", i),    {28'd0, status},     {28'd0, vec[i].e_st});
            chk($sformatf("tab%0d status_m1", i), {28'd0, m_status},   {28'd0, vec[i].e_stm});
            chk($sformatf("tab%0d sticky", i),    {31'd0, sticky_ovf}, {31'd0, vec[i].e_sticky});
            chk($sformatf("tab%0d op_count", i),  {16'd0, op_count},   {16'd0, vec[i].e_cnt});
`endif
            cycle_end(1);
        end

`ifdef ALU_WB_BYPASS_EN
        // Same-cycle forwarding from an empty stage
        drive(1, 0, 8'd0, 4'd0, 4'd0, 0, 0);
        #1;
        cycle_end(0);
        drive(0, 1, 8'hFE, 4'd0, 4'b0000, 1, 0);
        #1;
        chk("byp out_valid", {31'd0, out_valid}, 32'd1);
        chk("byp out_data",  {24'd0, out_data},  32'hFE);
        cycle_end(1);
        drive(0, 0, 8'd0, 4'd0, 4'd0, 0, 0);
        #1;
        chk("byp after out_valid", {31'd0, out_valid}, 32'd0);
        chk("byp after in_ready",  {31'd0, in_ready},  32'd1);
        chk("byp after op_count",  {16'd0, op_count},  32'd1);
        chk("byp after out_data",  {24'd0, out_data},  32'hFE);
        cycle_end(1);
`endif

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 70),
                  8'($urandom),
                  4'($urandom_range(0, 15)),
                  4'($urandom),
                  ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 10));
            #1;
            cycle_end(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Write-back stage directly downstream of the 8-bit combinational ALU (ports x, y, sel, out, zero, carry, overflow, negative).
- Accepts each ALU result plus its flags and opcode tag over a valid/ready handshake.
- Buffers results in a small FIFO toward the register-file / consumer side.
- Maintains the architectural status register {N,V,C,Z}, a sticky overflow bit and an accepted-operation counter.

Parameters:
- WIDTH, 8, data width of ALU result.
- DEPTH, 2, FIFO entries; power of 2, >= 2.
- FLAG_MASK, 16'h7FFF, bit k=1 means opcode sel==k updates the status register.
- CNT_W, 16, width of the operation counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept
- in_data  in  WIDTH  ALU out
- in_sel  in  4  opcode that produced in_data
- in_zero, in_carry, in_overflow, in_negative  in  1 each  ALU flags
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  WIDTH  head result
- out_flags  out  4  head flags {N,V,C,Z}
- out_sel  out  4  head opcode tag
- status  out  4  architectural flags {N,V,C,Z}
- sticky_ovf  out  1  set by any accepted result with overflow=1
- clr_sticky  in  1  clears sticky_ovf
- op_count  out  CNT_W  number of accepted results, wraps

Behaviour:
- Reset (rst=1 at a clock edge): FIFO empty, out_valid=0, in_ready=1, out_data/out_flags/out_sel=0, status=4'b0000, sticky_ovf=0, op_count=0. Reset overrides every other input, including mid-transfer; buffered entries are discarded.
- Accept: in_valid & in_ready at an edge. Push {sel, flags, data}; op_count += 1, wrapping modulo 2^CNT_W.
- Deliver: out_valid & out_ready at an edge. Pop head.
- in_ready = (count < DEPTH). Registered-only: no combinational path from out_ready to in_ready, so a full FIFO refuses a push even when a pop occurs that cycle.
- Latency: an entry accepted at edge N is presented with out_valid=1 after edge N (visible in cycle N+1).
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count is (log2(DEPTH)+1) bits.
- out_data/out_flags/out_sel hold the head value while out_valid=1 && out_ready=0; they are stable and must not change.
- When empty, outputs retain the last popped value; consumers ignore them while out_valid=0.
- Status register: on accept, if FLAG_MASK[in_sel]=1, status <= {in_negative, in_overflow, in_carry, in_zero}; otherwise status holds. Updated at accept time, not delivery time.
- sticky_ovf: set on accept with in_overflow=1, regardless of FLAG_MASK. Cleared by clr_sticky. If set and clear occur in the same edge, set wins.
- in_data is never modified; flags are taken from the ALU, not recomputed.

Optional Feature:
- Macro: ALU_WB_BYPASS_EN.
- Defined: when count==0 && in_valid && out_ready, out_valid=1 combinationally and in_data/flags/sel drive the out_* ports in the same cycle. The entry is not written into the FIFO. Status, sticky_ovf and op_count update exactly as for a normal accept.
- Undefined: minimum latency is one cycle as described above, and no combinational in-to-out path exists.

Decomposition:
- Shared package alu_pkg:
  - flag index constants FLG_Z=0, FLG_C=1, FLG_V=2, FLG_N=3
  - ALU opcode constants for sel 0..14, also used by the ALU and its bench
  - a packed typedef for the {sel, flags, data} entry
- One sub-module, alu_wb_fifo: generic DEPTH x entry synchronous FIFO with push/pop/count. The top level holds the handshake, status register, sticky bit and counter.

Test Plan:
- Reset, then push x=25,y=15 add result (in_data=40, flags 0000, sel=0) with out_ready=1 -> out_valid next cycle, out_data=40, status=0000, op_count=1.
- Push 128+128 (in_data=0, Z=1, C=1, V=1, N=0, sel=0) -> status=4'b0111, sticky_ovf=1. Then assert clr_sticky together with another V=1 accept -> sticky_ovf stays 1.
- out_ready=0, push 3 results (10, 20, 30) -> in_ready=0 after the 2nd accept and the 3rd is held. Raise out_ready -> pops in order 10, 20, 30; op_count=3.
- FLAG_MASK=16'h0001: accept sel=5 with Z=1 -> status unchanged; accept sel=0 with Z=1 -> status[0]=1.
- Assert rst with 2 entries buffered and in_valid=1 -> next cycle out_valid=0, status=0, op_count=0, in_ready=1.
- With ALU_WB_BYPASS_EN, empty FIFO, in_valid=1, out_ready=1, in_data=8'hFE -> out_valid=1 and out_data=8'hFE in the same cycle; count stays 0.
